// File: rtl/light_bar_pkg.sv
// rtl/light_bar_pkg.sv - mode encodings, default pattern table and idle frames for the LED bar
package light_bar_pkg;

  localparam logic [1:0] MODE_LOOP     = 2'b00;
  localparam logic [1:0] MODE_PINGPONG = 2'b01;
  localparam logic [1:0] MODE_ONESHOT  = 2'b10;
  localparam logic [1:0] MODE_HOLD     = 2'b11;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int DEFAULT_DEPTH = 8;

  localparam logic [7:0] DEFAULT_GREEN [0:7] = '{
    8'b11001111, 8'b01100000, 8'b00111111, 8'b11001111,
    8'b01010101, 8'b10101010, 8'b11001100, 8'b00110011
  };

  localparam logic [7:0] DEFAULT_RED [0:7] = '{
    8'b11110011, 8'b00001100, 8'b11111100, 8'b11110011,
    8'b10101010, 8'b01010101, 8'b00110011, 8'b11001100
  };

  localparam logic [7:0] IDLE_GREEN_FRAME = 8'b10010101;
  localparam logic [7:0] IDLE_RED_FRAME   = 8'b10101001;

  // Index width for a table of n entries; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/light_pattern_sequencer_step_prescaler.sv
// rtl/light_pattern_sequencer_step_prescaler.sv - free-running step prescaler with count enable and sync clear
module step_prescaler #(
  parameter int TICKS = 25000000,
  localparam int CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1
) (
  input  logic clock,
  input  logic clear,
  input  logic cnt_en,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = cnt_en && (cnt_q == LAST);

  // With cnt_en low the count is simply held, so a paused step resumes where it left off.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/light_pattern_sequencer.sv
// rtl/light_pattern_sequencer.sv - two-colour LED bar pattern sequencer with writable table and four play modes
module light_pattern_sequencer
  import light_bar_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int NUM_PATTERNS = 8,
  parameter int STEP_TICKS   = 25000000,
  parameter logic [WIDTH-1:0] IDLE_GREEN = WIDTH'(IDLE_GREEN_FRAME),
  parameter logic [WIDTH-1:0] IDLE_RED   = WIDTH'(IDLE_RED_FRAME),
  localparam int IDX_W = idx_width(NUM_PATTERNS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [IDX_W-1:0] length,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_green,
  input  logic [WIDTH-1:0] wr_red,
  output logic [WIDTH-1:0] greenLight,
  output logic [WIDTH-1:0] redLight,
  output logic [IDX_W-1:0] disp_index,
  output logic             step,
  output logic             done
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_PATTERNS - 1);
  localparam logic [IDX_W:0]   DEPTH_EXT = (IDX_W + 1)'(NUM_PATTERNS);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  logic [WIDTH-1:0] green_tbl_q [NUM_PATTERNS];
  logic [WIDTH-1:0] green_tbl_d [NUM_PATTERNS];
  logic [WIDTH-1:0] red_tbl_q   [NUM_PATTERNS];
  logic [WIDTH-1:0] red_tbl_d   [NUM_PATTERNS];

  logic [WIDTH-1:0] green_q, green_d;
  logic [WIDTH-1:0] red_q, red_d;
  logic [IDX_W-1:0] disp_q, disp_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  dir_e             dir_q, dir_d;
  logic             step_q, step_d;
  logic             done_q, done_d;
  logic [1:0]       mode_q, mode_d;

  logic             tick;
  logic             cnt_en;
  logic             cnt_clr;
  logic [IDX_W-1:0] len_c;
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] nxt_idx;
  dir_e             cur_dir;
  dir_e             nxt_dir;

  assign cnt_en  = enable && (mode != MODE_HOLD) && !done_q;
  assign cnt_clr = reset || !enable;

  step_prescaler #(
    .TICKS(STEP_TICKS)
  ) u_prescaler (
    .clock  (clock),
    .clear  (cnt_clr),
    .cnt_en (cnt_en),
    .tick   (tick)
  );

  // Writes land in the _q table one edge later, so a same-cycle tick reads the old frame.
  always_comb begin
    for (int i = 0; i < NUM_PATTERNS; i++) begin
      green_tbl_d[i] = green_tbl_q[i];
      red_tbl_d[i]   = red_tbl_q[i];
    end
    if (wr_en && ({1'b0, wr_addr} < DEPTH_EXT)) begin
      green_tbl_d[wr_addr] = wr_green;
      red_tbl_d[wr_addr]   = wr_red;
    end
  end

  // Pointer selection: a pointer left beyond a shortened sequence restarts at entry 0 going up.
  always_comb begin
    len_c   = ({1'b0, length} >= DEPTH_EXT) ? LAST_IDX : length;
    cur_idx = ptr_q;
    cur_dir = dir_q;
    if (ptr_q > len_c) begin
      cur_idx = '0;
      cur_dir = DIR_UP;
    end
    nxt_idx = cur_idx;
    nxt_dir = cur_dir;
    if (mode == MODE_PINGPONG) begin
      if (len_c == '0) begin
        nxt_idx = '0;
        nxt_dir = DIR_UP;
      end else if (cur_dir == DIR_UP) begin
        if (cur_idx == len_c) begin
          nxt_idx = len_c - IDX_ONE;
          nxt_dir = DIR_DOWN;
        end else begin
          nxt_idx = cur_idx + IDX_ONE;
        end
      end else begin
        if (cur_idx == '0) begin
          nxt_idx = IDX_ONE;
          nxt_dir = DIR_UP;
        end else begin
          nxt_idx = cur_idx - IDX_ONE;
        end
      end
    end else begin
      nxt_idx = (cur_idx == len_c) ? '0 : cur_idx + IDX_ONE;
    end
  end

  always_comb begin
    green_d = green_q;
    red_d   = red_q;
    disp_d  = disp_q;
    ptr_d   = ptr_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    done_d  = done_q;
    mode_d  = mode;
    if (!enable) begin
      green_d = IDLE_GREEN;
      red_d   = IDLE_RED;
      disp_d  = '0;
      ptr_d   = '0;
      dir_d   = DIR_UP;
      done_d  = 1'b0;
    end else begin
      if (tick) begin
        green_d = green_tbl_q[cur_idx];
        red_d   = red_tbl_q[cur_idx];
        disp_d  = cur_idx;
        ptr_d   = nxt_idx;
        dir_d   = nxt_dir;
        step_d  = 1'b1;
        if ((mode == MODE_ONESHOT) && (cur_idx == len_c)) begin
          done_d = 1'b1;
        end
      end
      if (mode != mode_q) begin
        done_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      green_q <= IDLE_GREEN;
      red_q   <= IDLE_RED;
      disp_q  <= '0;
      ptr_q   <= '0;
      dir_q   <= DIR_UP;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= MODE_LOOP;
      for (int i = 0; i < NUM_PATTERNS; i++) begin
        green_tbl_q[i] <= WIDTH'(DEFAULT_GREEN[i % DEFAULT_DEPTH]);
        red_tbl_q[i]   <= WIDTH'(DEFAULT_RED[i % DEFAULT_DEPTH]);
      end
    end else begin
      green_q     <= green_d;
      red_q       <= red_d;
      disp_q      <= disp_d;
      ptr_q       <= ptr_d;
      dir_q       <= dir_d;
      step_q      <= step_d;
      done_q      <= done_d;
      mode_q      <= mode_d;
      green_tbl_q <= green_tbl_d;
      red_tbl_q   <= red_tbl_d;
    end
  end

  assign greenLight = green_q;
  assign redLight   = red_q;
  assign disp_index = disp_q;
  assign step       = step_q;
  assign done       = done_q;

endmodule

// File: tb/tb_light_pattern_sequencer.sv
// tb/tb_light_pattern_sequencer.sv - directed self-checking bench for light_pattern_sequencer
module tb_light_pattern_sequencer;

  localparam int W  = 8;
  localparam int NP = 8;
  localparam int IW = 3;
  localparam int ST = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [1:0]    mode;
  logic [IW-1:0] length;
  logic          wr_en;
  logic [IW-1:0] wr_addr;
  logic [W-1:0]  wr_green;
  logic [W-1:0]  wr_red;
  logic [W-1:0]  greenLight;
  logic [W-1:0]  redLight;
  logic [IW-1:0] disp_index;
  logic          step;
  logic          done;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_g [0:7] = '{8'hCF, 8'h60, 8'h3F, 8'hCF, 8'h55, 8'hAA, 8'hCC, 8'h33};
  logic [7:0] exp_r [0:7] = '{8'hF3, 8'h0C, 8'hFC, 8'hF3, 8'hAA, 8'h55, 8'h33, 8'hCC};

  light_pattern_sequencer #(
    .WIDTH(W),
    .NUM_PATTERNS(NP),
    .STEP_TICKS(ST)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .length     (length),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_green   (wr_green),
    .wr_red     (wr_red),
    .greenLight (greenLight),
    .redLight   (redLight),
    .disp_index (disp_index),
    .step       (step),
    .done       (done)
  );

  always #5 clock = ~clock;

  task automatic edges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic restart(input logic [1:0] m, input logic [IW-1:0] l);
    enable = 1'b0;
    edges(1);
    mode   = m;
    length = l;
    enable = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b0; mode = 2'b00; length = 3'd7;
    wr_en = 1'b0; wr_addr = '0; wr_green = '0; wr_red = '0;
    edges(2);
    n_cmp++; if (greenLight !== 8'h95) begin n_err++; $display("FAIL reset_green got %h want 95", greenLight); end
    n_cmp++; if (redLight !== 8'hA9) begin n_err++; $display("FAIL reset_red got %h want a9", redLight); end
    n_cmp++; if (disp_index !== 3'd0) begin n_err++; $display("FAIL reset_disp got %0d want 0", disp_index); end
    n_cmp++; if (step !== 1'b0) begin n_err++; $display("FAIL reset_step got %b want 0", step); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
  endtask

  task automatic test_loop;
    logic [IW-1:0] e;
    reset = 1'b0; enable = 1'b1; mode = 2'b00; length = 3'd7;
    edges(3);
    n_cmp++; if (step !== 1'b0) begin n_err++; $display("FAIL loop_early_step got %b want 0", step); end
    edges(1);
    n_cmp++; if (step !== 1'b1) begin n_err++; $display("FAIL loop_first_step got %b want 1", step); end
    n_cmp++; if (disp_index !== 3'd0) begin n_err++; $display("FAIL loop_first_disp got %0d want 0", disp_index); end
    n_cmp++; if (greenLight !== 8'hCF) begin n_err++; $display("FAIL loop_first_green got %h want cf", greenLight); end
    n_cmp++; if (redLight !== 8'hF3) begin n_err++; $display("FAIL loop_first_red got %h want f3", redLight); end
    edges(1);
    n_cmp++; if (step !== 1'b0) begin n_err++; $display("FAIL loop_step_width got %b want 0", step); end
    edges(3);
    for (int k = 1; k <= 8; k++) begin
      e = 3'(k % 8);
      n_cmp++; if (step !== 1'b1) begin n_err++; $display("FAIL loop_step[%0d] got %b want 1", k, step); end
      n_cmp++; if (disp_index !== e) begin n_err++; $display("FAIL loop_disp[%0d] got %0d want %0d", k, disp_index, e); end
      n_cmp++; if (greenLight !== exp_g[k % 8]) begin n_err++; $display("FAIL loop_green[%0d] got %h want %h", k, greenLight, exp_g[k % 8]); end
      n_cmp++; if (redLight !== exp_r[k % 8]) begin n_err++; $display("FAIL loop_red[%0d] got %h want %h", k, redLight, exp_r[k % 8]); end
      if (k < 8) edges(4);
    end
  endtask

  task automatic test_pingpong;
    logic [IW-1:0] seq [0:5];
    seq = '{3'd0, 3'd1, 3'd2, 3'd1, 3'd0, 3'd1};
    restart(2'b01, 3'd2);
    for (int i = 0; i < 6; i++) begin
      edges(3);
      n_cmp++; if (step !== 1'b0) begin n_err++; $display("FAIL pp_gap[%0d] got %b want 0", i, step); end
      edges(1);
      n_cmp++; if (step !== 1'b1) begin n_err++; $display("FAIL pp_step[%0d] got %b want 1", i, step); end
      n_cmp++; if (disp_index !== seq[i]) begin n_err++; $display("FAIL pp_disp[%0d] got %0d want %0d", i, disp_index, seq[i]); end
    end
    length = 3'd0;
    for (int i = 0; i < 3; i++) begin
      edges(4);
      n_cmp++; if (step !== 1'b1) begin n_err++; $display("FAIL pp0_step[%0d] got %b want 1", i, step); end
      n_cmp++; if (disp_index !== 3'd0) begin n_err++; $display("FAIL pp0_disp[%0d] got %0d want 0", i, disp_index); end
    end
  endtask

  task automatic test_oneshot;
    logic [IW-1:0] e;
    int pulses;
    restart(2'b10, 3'd3);
    for (int i = 0; i < 4; i++) begin
      e = 3'(i);
      edges(4);
      n_cmp++; if (step !== 1'b1) begin n_err++; $display("FAIL os_step[%0d] got %b want 1", i, step); end
      n_cmp++; if (disp_index !== e) begin n_err++; $display("FAIL os_disp[%0d] got %0d want %0d", i, disp_index, e); end
      if (i == 2) begin
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL os_done_early got %b want 0", done); end
      end
    end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL os_done got %b want 1", done); end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      edges(1);
      if (step === 1'b1) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL os_extra_steps got %0d want 0", pulses); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL os_done_sticky got %b want 1", done); end
    n_cmp++; if (greenLight !== 8'hCF) begin n_err++; $display("FAIL os_green_frozen got %h want cf", greenLight); end
    n_cmp++; if (redLight !== 8'hF3) begin n_err++; $display("FAIL os_red_frozen got %h want f3", redLight); end
    mode = 2'b00;
    edges(1);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL os_done_clear got %b want 0", done); end
    edges(3);
    n_cmp++; if (step !== 1'b0) begin n_err++; $display("FAIL os_resume_gap got %b want 0", step); end
    edges(1);
    n_cmp++; if (step !== 1'b1) begin n_err++; $display("FAIL os_resume_step got %b want 1", step); end
    n_cmp++; if (disp_index !== 3'd0) begin n_err++; $display("FAIL os_resume_disp got %0d want 0", disp_index); end
  endtask

  task automatic test_write_collision;
    restart(2'b00, 3'd7);
    edges(7);
    wr_en = 1'b1; wr_addr = 3'd1; wr_green = 8'hFF; wr_red = 8'h00;
    edges(1);
    wr_en = 1'b0;
    n_cmp++; if (disp_index !== 3'd1) begin n_err++; $display("FAIL wr_coll_disp got %0d want 1", disp_index); end
    n_cmp++; if (greenLight !== 8'h60) begin n_err++; $display("FAIL wr_coll_green got %h want 60", greenLight); end
    n_cmp++; if (redLight !== 8'h0C) begin n_err++; $display("FAIL wr_coll_red got %h want 0c", redLight); end
    edges(32);
    n_cmp++; if (step !== 1'b1) begin n_err++; $display("FAIL wr_next_step got %b want 1", step); end
    n_cmp++; if (disp_index !== 3'd1) begin n_err++; $display("FAIL wr_next_disp got %0d want 1", disp_index); end
    n_cmp++; if (greenLight !== 8'hFF) begin n_err++; $display("FAIL wr_next_green got %h want ff", greenLight); end
    n_cmp++; if (redLight !== 8'h00) begin n_err++; $display("FAIL wr_next_red got %h want 00", redLight); end
  endtask

  task automatic test_enable_drop;
    edges(2);
    enable = 1'b0;
    edges(1);
    n_cmp++; if (greenLight !== 8'h95) begin n_err++; $display("FAIL idle_green got %h want 95", greenLight); end
    n_cmp++; if (redLight !== 8'hA9) begin n_err++; $display("FAIL idle_red got %h want a9", redLight); end
    n_cmp++; if (disp_index !== 3'd0) begin n_err++; $display("FAIL idle_disp got %0d want 0", disp_index); end
    n_cmp++; if (step !== 1'b0) begin n_err++; $display("FAIL idle_step got %b want 0", step); end
    enable = 1'b1;
    edges(3);
    n_cmp++; if (step !== 1'b0) begin n_err++; $display("FAIL reen_gap got %b want 0", step); end
    edges(1);
    n_cmp++; if (step !== 1'b1) begin n_err++; $display("FAIL reen_step got %b want 1", step); end
    n_cmp++; if (disp_index !== 3'd0) begin n_err++; $display("FAIL reen_disp got %0d want 0", disp_index); end
    n_cmp++; if (greenLight !== 8'hCF) begin n_err++; $display("FAIL reen_green got %h want cf", greenLight); end
  endtask

  task automatic test_hold;
    int pulses;
    edges(2);
    mode = 2'b11;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      edges(1);
      if (step === 1'b1) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL hold_steps got %0d want 0", pulses); end
    n_cmp++; if (disp_index !== 3'd0) begin n_err++; $display("FAIL hold_disp got %0d want 0", disp_index); end
    mode = 2'b00;
    edges(1);
    n_cmp++; if (step !== 1'b0) begin n_err++; $display("FAIL hold_resume_gap got %b want 0", step); end
    edges(1);
    n_cmp++; if (step !== 1'b1) begin n_err++; $display("FAIL hold_resume_step got %b want 1", step); end
    n_cmp++; if (disp_index !== 3'd1) begin n_err++; $display("FAIL hold_resume_disp got %0d want 1", disp_index); end
    n_cmp++; if (greenLight !== 8'hFF) begin n_err++; $display("FAIL hold_resume_green got %h want ff", greenLight); end
    edges(4);
    n_cmp++; if (disp_index !== 3'd2) begin n_err++; $display("FAIL hold_after_disp got %0d want 2", disp_index); end
  endtask

  task automatic test_reset_midrun;
    edges(2);
    reset = 1'b1;
    edges(1);
    n_cmp++; if (greenLight !== 8'h95) begin n_err++; $display("FAIL rst_mid_green got %h want 95", greenLight); end
    reset = 1'b0;
    edges(8);
    n_cmp++; if (disp_index !== 3'd1) begin n_err++; $display("FAIL rst_mid_disp got %0d want 1", disp_index); end
    n_cmp++; if (greenLight !== 8'h60) begin n_err++; $display("FAIL rst_mid_green_tbl got %h want 60", greenLight); end
    n_cmp++; if (redLight !== 8'h0C) begin n_err++; $display("FAIL rst_mid_red_tbl got %h want 0c", redLight); end
  endtask

  initial begin
    test_reset;
    test_loop;
    test_pingpong;
    test_oneshot;
    test_write_collision;
    test_enable_drop;
    test_hold;
    test_reset_midrun;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
